// File: rtl/ins_fetch_sequencer.sv
// Instruction fetch/commit sequencer: owns the PC, fetches words from instruction memory,
// gives the executor one commit pulse per instruction and then applies its PCnew redirect.
module ins_fetch_sequencer #(
    parameter int          ADDR_W    = 6,
    parameter int          MAX_PC    = 63,
    parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
    parameter int          TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [31:0]       ins,
    output logic [31:0]       PC,
    output logic              exec_en,
    input  logic [31:0]       PCnew,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       ins_count
);
    localparam int                WCNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(MAX_PC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_UPDATE,
        S_PAUSE,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ins_q, ins_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              fault_q, fault_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] redirect;
    logic              unused_pcnew_hi;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Only the low address bits of PCnew matter; a zero there means fall-through.
    assign redirect        = PCnew[ADDR_W-1:0];
    assign unused_pcnew_hi = ^PCnew[31:ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ins_q   <= '0;
            wcnt_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ins_q   <= ins_d;
            wcnt_q  <= wcnt_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ins_d   = ins_q;
        wcnt_d  = '0;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (imem_valid) begin
                    if (imem_rdata == HALT_WORD) begin
                        state_d = S_HALT;
                    end else begin
                        ins_d   = imem_rdata;
                        state_d = S_EXEC;
                    end
                end else if (wcnt_q == WCNT_LAST) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_EXEC: begin
                cnt_d   = sat_inc16(cnt_q);
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                state_d = step_mode ? S_PAUSE : S_FETCH;
                if (redirect != '0) begin
                    pc_d = redirect;
                end else if (pc_q == PC_LAST) begin
                    state_d = S_HALT;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (step || !step_mode) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reset suppresses the request and the commit pulse in the cycle it is asserted.
    assign imem_req  = (state_q == S_FETCH) && !rst;
    assign exec_en   = (state_q == S_EXEC) && !rst;
    assign imem_addr = pc_q;
    assign PC        = 32'(pc_q);
    assign ins       = ins_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                       (state_q == S_UPDATE) || (state_q == S_PAUSE);
    assign halted    = (state_q == S_HALT);
    assign fault     = fault_q;
    assign ins_count = cnt_q;

endmodule
